// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings, default slot bases, slot-index and default-slave state enums
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [7:0] BASE0_DEF = 8'h00;
  localparam logic [7:0] BASE1_DEF = 8'h20;
  localparam logic [7:0] BASE2_DEF = 8'h50;
  localparam logic [7:0] BASE3_DEF = 8'h51;
  typedef enum logic [2:0] {S0, S1, S2, S3, DEF} slot_e;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: two-cycle ERROR responder for unmapped active transfers; in HCLK/HRESETn/HSEL/HREADY/HTRANS, out HREADYOUT/HRESP
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       HSEL,
  input  logic       HREADY,
  input  logic [1:0] HTRANS,
  output logic       HREADYOUT,
  output logic       HRESP
);
  ds_state_e state_q, state_d;
  logic start;
  always_comb begin
    start = HSEL && HREADY && HTRANS != HTRANS_IDLE && HTRANS != HTRANS_BUSY;
    state_d = state_q == DS_ERR1 ? DS_ERR2 : start ? DS_ERR1 : DS_IDLE;
    HREADYOUT = state_q != DS_ERR1;
    HRESP = state_q == DS_IDLE ? HRESP_OKAY : HRESP_ERROR;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) state_q <= DS_IDLE;
    else state_q <= state_d;
endmodule

// File: rtl/ahb_decode_mux.sv
// ahb_decode_mux: AHB address decoder for four slots plus default slave, with data-phase response mux; in HADDR/HTRANS/slave responses, out HSEL_Sn and HREADY/HRESP/HRDATA
module ahb_decode_mux
  import ahb_pkg::*;
#(
  parameter logic [7:0] BASE0 = BASE0_DEF,
  parameter logic [7:0] BASE1 = BASE1_DEF,
  parameter logic [7:0] BASE2 = BASE2_DEF,
  parameter logic [7:0] BASE3 = BASE3_DEF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  output logic        HSEL_S0,
  output logic        HSEL_S1,
  output logic        HSEL_S2,
  output logic        HSEL_S3,
  input  logic        HREADYOUT_S0,
  input  logic        HREADYOUT_S1,
  input  logic        HREADYOUT_S2,
  input  logic        HREADYOUT_S3,
  input  logic        HRESP_S0,
  input  logic        HRESP_S1,
  input  logic        HRESP_S2,
  input  logic        HRESP_S3,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  input  logic [31:0] HRDATA_S3,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);
  slot_e addr_slot, sel_q, sel_d;
  logic def_ready, def_resp, unused_addr;
  assign unused_addr = ^HADDR[23:0];
  always_comb begin
    addr_slot = HADDR[31:24] == BASE0 ? S0 :
                HADDR[31:24] == BASE1 ? S1 :
                HADDR[31:24] == BASE2 ? S2 :
                HADDR[31:24] == BASE3 ? S3 : DEF;
    HSEL_S0 = addr_slot == S0;
    HSEL_S1 = addr_slot == S1;
    HSEL_S2 = addr_slot == S2;
    HSEL_S3 = addr_slot == S3;
    HREADY = sel_q == S0 ? HREADYOUT_S0 : sel_q == S1 ? HREADYOUT_S1 :
             sel_q == S2 ? HREADYOUT_S2 : sel_q == S3 ? HREADYOUT_S3 : def_ready;
    HRESP = sel_q == S0 ? HRESP_S0 : sel_q == S1 ? HRESP_S1 :
            sel_q == S2 ? HRESP_S2 : sel_q == S3 ? HRESP_S3 : def_resp;
    HRDATA = sel_q == S0 ? HRDATA_S0 : sel_q == S1 ? HRDATA_S1 :
             sel_q == S2 ? HRDATA_S2 : sel_q == S3 ? HRDATA_S3 : 32'h0;
    // a stalled data phase keeps its slot; the pending address phase waits
    sel_d = HREADY ? addr_slot : sel_q;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) sel_q <= DEF;
    else sel_q <= sel_d;
  ahb_default_slave u_def (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (addr_slot == DEF),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .HREADYOUT (def_ready),
    .HRESP     (def_resp)
  );
endmodule

// File: tb/tb_ahb_decode_mux.sv
// tb_ahb_decode_mux: randomized scoreboard bench with behavioural slaves and a transfer-level reference model
module tb_ahb_decode_mux;
  logic HCLK = 0, HRESETn = 0;
  logic [31:0] HADDR = 0;
  logic [1:0] HTRANS = 0;
  logic [3:0] hsel, s_rdy, s_resp;
  logic [31:0] s_data [4];
  logic HREADY, HRESP;
  logic [31:0] HRDATA;
  always #5 HCLK = ~HCLK;
  ahb_decode_mux dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_S0(hsel[0]), .HSEL_S1(hsel[1]), .HSEL_S2(hsel[2]), .HSEL_S3(hsel[3]),
    .HREADYOUT_S0(s_rdy[0]), .HREADYOUT_S1(s_rdy[1]), .HREADYOUT_S2(s_rdy[2]), .HREADYOUT_S3(s_rdy[3]),
    .HRESP_S0(s_resp[0]), .HRESP_S1(s_resp[1]), .HRESP_S2(s_resp[2]), .HRESP_S3(s_resp[3]),
    .HRDATA_S0(s_data[0]), .HRDATA_S1(s_data[1]), .HRDATA_S2(s_data[2]), .HRDATA_S3(s_data[3]),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );
  typedef struct {int waits; logic resp; logic [31:0] data;} exp_t;
  exp_t q[$];
  exp_t cur;
  int checks = 0, failures = 0, w = 0;
  bit addr_valid = 0, in_data = 0;
  logic [7:0] bases [4] = '{8'h00, 8'h20, 8'h50, 8'h51};
  logic [31:0] salts [4] = '{32'h0F0F_1111, 32'h3234_5668, 32'h5A5A_0000, 32'h00C3_3C00};
  // slave n: wait states = HADDR[4:3], resp = HADDR[6], data = HADDR ^ salt; idle pattern otherwise
  logic act [4];
  logic [1:0] cnt [4];
  logic [31:0] la [4];
  always @(posedge HCLK or negedge HRESETn)
    for (int n = 0; n < 4; n++)
      if (!HRESETn) act[n] <= 0;
      else if (HREADY && hsel[n] && HTRANS[1]) begin
        act[n] <= 1;
        cnt[n] <= HADDR[4:3];
        la[n] <= HADDR;
      end else if (HREADY) act[n] <= 0;
      else if (cnt[n] != 0) cnt[n] <= cnt[n] - 2'd1;
  always_comb
    for (int n = 0; n < 4; n++) begin
      s_rdy[n] = !act[n] || cnt[n] == 0;
      s_resp[n] = act[n] && la[n][6];
      s_data[n] = act[n] ? la[n] ^ salts[n] : 32'hDEAD_0000 | n;
    end
  function automatic int slot_of(logic [31:0] a);
    for (int i = 0; i < 4; i++) if (a[31:24] == bases[i]) return i;
    return 4;
  endfunction
  function automatic exp_t model(logic [31:0] a, logic [1:0] t);
    exp_t e;
    int s = slot_of(a);
    bit active = (t == 2'd2 || t == 2'd3);
    if (s == 4) begin
      e.waits = active ? 1 : 0;
      e.resp = active;
      e.data = 0;
    end else begin
      e.waits = active ? int'(a[4:3]) : 0;
      e.resp = active && a[6];
      e.data = active ? a ^ salts[s] : 32'hDEAD_0000 | s;
    end
    return e;
  endfunction
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask
  task automatic issue(logic [31:0] a, logic [1:0] t);
    int k = 0;
    @(posedge HCLK);
    #1;
    HADDR = a;
    HTRANS = t;
    addr_valid = 1;
    q.push_back(model(a, t));
    do begin
      @(negedge HCLK);
      k++;
    end while (!HREADY && k < 20);
    if (!HREADY) chk("accept_timeout", {31'b0, HREADY}, 1);
  endtask
  task automatic go_idle();
    @(posedge HCLK);
    #1;
    HTRANS = 2'd0;
    addr_valid = 0;
  endtask
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      in_data = 0;
      q.delete();
    end else begin
      chk("hsel", {28'b0, hsel}, slot_of(HADDR) < 4 ? 32'd1 << slot_of(HADDR) : 32'd0);
      if (in_data) begin
        chk("hresp", {31'b0, HRESP}, {31'b0, cur.resp});
        if (HREADY) begin
          chk("hrdata", HRDATA, cur.data);
          chk("waits", w, cur.waits);
          in_data = 0;
        end else if (++w > 16) begin
          chk("stall_timeout", w, cur.waits);
          in_data = 0;
        end
      end
      if (HREADY && addr_valid) begin
        if (q.size() == 0) chk("queue_empty", 0, 1);
        else cur = q.pop_front();
        in_data = 1;
        w = 0;
      end
    end
  end
  initial begin
    #12;
    chk("rst_hready", {31'b0, HREADY}, 1);
    chk("rst_hresp", {31'b0, HRESP}, 0);
    chk("rst_hrdata", HRDATA, 0);
    @(posedge HCLK);
    #3 HRESETn = 1;
    issue(32'h5000_0000, 2'd2);
    issue(32'h2000_0010, 2'd2);
    issue(32'h5100_0000, 2'd2);
    issue(32'h3000_0000, 2'd2);
    issue(32'h3000_0000, 2'd0);
    issue(32'h3000_0000, 2'd2);
    issue(32'h3100_0004, 2'd3);
    issue(32'h3000_0000, 2'd2);
    issue(32'h3000_0000, 2'd1);
    issue(32'h3000_0000, 2'd2);
    go_idle();
    #1;
    chk("err1_hready", {31'b0, HREADY}, 0);
    chk("err1_hresp", {31'b0, HRESP}, 1);
    #1 HRESETn = 0;
    #1;
    chk("async_hready", {31'b0, HREADY}, 1);
    chk("async_hresp", {31'b0, HRESP}, 0);
    chk("async_hrdata", HRDATA, 0);
    repeat (2) @(negedge HCLK);
    @(posedge HCLK);
    #3 HRESETn = 1;
    issue(32'h2000_0008, 2'd2);
    issue(32'h0000_0040, 2'd2);
    for (int i = 0; i < 300; i++) begin
      logic [7:0] his [7] = '{8'h00, 8'h20, 8'h50, 8'h51, 8'h30, 8'h7F, 8'hFF};
      logic [31:0] lo = $urandom;
      issue({his[$urandom_range(0, 6)], lo[23:0]}, 2'($urandom_range(0, 3)));
    end
    go_idle();
    repeat (6) @(negedge HCLK);
    chk("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_decode_mux.md
AHB_DECODE_MUX -- requirements
Module: ahb_decode_mux

Interface
REQ-001 SHALL have parameter BASE0, default 8'h00, HADDR[31:24] of slot 0 (code memory).
REQ-002 SHALL have parameter BASE1, default 8'h20, HADDR[31:24] of slot 1 (SRAM).
REQ-003 SHALL have parameter BASE2, default 8'h50, HADDR[31:24] of slot 2 (LED peripheral).
REQ-004 SHALL have parameter BASE3, default 8'h51, HADDR[31:24] of slot 3 (GPIO/switch peripheral).
REQ-005 SHALL have port HCLK, input, 1, bus clock.
REQ-006 SHALL have port HRESETn, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port HADDR, input, 32, master address-phase address.
REQ-008 SHALL have port HTRANS, input, 2, master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-009 SHALL have ports HSEL_S0..HSEL_S3, output, 1 each, address-phase slave selects.
REQ-010 SHALL have ports HREADYOUT_S0..HREADYOUT_S3, input, 1 each, slave ready.
REQ-011 SHALL have ports HRESP_S0..HRESP_S3, input, 1 each, slave response (0=OKAY, 1=ERROR); unused or OKAY-only slaves are tied 0 at integration.
REQ-012 SHALL have ports HRDATA_S0..HRDATA_S3, input, 32 each, slave read data.
REQ-013 SHALL have port HREADY, output, 1, muxed ready to master and all slaves.
REQ-014 SHALL have port HRESP, output, 1, muxed response to master.
REQ-015 SHALL have port HRDATA, output, 32, muxed read data to master.

Function
REQ-016 SHALL drive HSEL_Sn combinationally as HADDR[31:24]==BASEn, independent of HTRANS and HREADY; at most one HSEL_Sn is high.
REQ-017 SHALL select the internal default slave when no BASEn matches.
REQ-018 SHALL hold a data-phase select register (values S0..S3, DEF), loaded with the current address-phase decode on each HCLK rising edge where HREADY=1, and held while HREADY=0.
REQ-019 SHALL drive HREADY, HRESP and HRDATA combinationally from the slot named by the data-phase select register.
REQ-020 SHALL drive HRDATA=32'h0 when the data-phase select is DEF.
REQ-021 SHALL implement the default slave as an FSM with states IDLE, ERR1 and ERR2.
REQ-022 SHALL, in IDLE, drive default-slave ready=1 and resp=OKAY.
REQ-023 SHALL move IDLE->ERR1 when HREADY=1, the default slave is selected and HTRANS is NONSEQ or SEQ.
REQ-024 SHALL stay in IDLE for IDLE or BUSY transfers to unmapped addresses, giving a zero-wait OKAY response.
REQ-025 SHALL, in ERR1, drive ready=0 and resp=ERROR, then move unconditionally to ERR2.
REQ-026 SHALL, in ERR2, drive ready=1 and resp=ERROR, then move to ERR1 if the next unmapped NONSEQ/SEQ is in its address phase, else to IDLE.
REQ-027 SHALL complete every mapped transfer with the selected slave's latency; the mux adds zero wait states.
REQ-028 SHALL ignore address and HTRANS changes while HREADY=0; the data-phase select is unaffected during slave stalls.
REQ-029 SHALL support back-to-back transfers to different slots with no bubble; the select switches on the edge that ends the previous data phase.

Reset
REQ-030 SHALL, while HRESETn=0, set the data-phase select to DEF and the FSM to IDLE.
REQ-031 SHALL therefore present HREADY=1, HRESP=0 and HRDATA=0 during reset.
REQ-032 SHALL start in that same state on reset release, even if reset was asserted mid-transfer or mid-ERROR.

Structure
REQ-033 SHALL take from shared package ahb_pkg: the HTRANS encodings, the HRESP encodings, the default BASEn constants and the slot-index enum (S0..S3, DEF).
REQ-034 SHALL place the default-slave FSM in sub-module ahb_default_slave, with ports HCLK, HRESETn, HSEL, HREADY, HTRANS, HREADYOUT and HRESP.

Verification
REQ-035 SHALL cover: write NONSEQ to 0x5000_0000 with data 0x0000_A5A5 -> HSEL_S2=1 in address phase, LED slave captures 0xA5A5, HREADY=1, HRESP=0.
REQ-036 SHALL cover: read from 0x2000_0010 with S1 holding HREADYOUT_S1=0 for 2 cycles and HRDATA_S1=0x1234_5678 -> HREADY low 2 cycles, then HRDATA=0x1234_5678; a concurrent address change to 0x5100_0000 is not selected until HREADY=1.
REQ-037 SHALL cover: NONSEQ to 0x3000_0000 -> cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1, HRDATA=0, then IDLE.
REQ-038 SHALL cover: IDLE transfer to 0x3000_0000 -> HREADY=1, HRESP=0 with no ERROR.
REQ-039 SHALL cover: back-to-back unmapped NONSEQs -> ERR1, ERR2, ERR1, ERR2 with no IDLE gap.
REQ-040 SHALL cover: HRESETn asserted during ERR1 -> HREADY=1, HRESP=0 and HRDATA=0 immediately (asynchronous), and the first transfer after release decodes correctly.
